// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweep sequencer.
package truth_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sweep_state_e;

   // Expected truth table of the 3-input decoder: codes 0, 2, 5 and 7 give 1.
   localparam logic [7:0] DEC5_EXP_MASK = 8'b1010_0101;

   // Settle delays of 0..15 cycles fit a 4-bit counter.
   localparam int unsigned SETTLE_W = 4;

   function automatic int unsigned num_codes(input int unsigned sel_w);
      return 32'd1 << sel_w;
   endfunction

endpackage

// File: rtl/truth_sweep_settle_cnt.sv
// Loadable down-counter with a zero flag, used to time the select settle window.
module truth_sweep_settle_cnt
   import truth_sweep_pkg::*;
#(
   parameter int unsigned W = SETTLE_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg <= '0;
      end else if (load_i) begin
         cnt_reg <= load_val_i;
      end else if (dec_i && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign zero_o = (cnt_reg == '0);

endmodule

// File: rtl/truth_sweep_ctrl.sv
// Sweeps a decoder's select through every code, samples its result after a
// settle delay and accumulates mismatches against an expected truth table.
module truth_sweep_ctrl
   import truth_sweep_pkg::*;
#(
   parameter int unsigned          SelW         = 3,
   parameter logic [2**SelW-1:0]   ExpMask      = DEC5_EXP_MASK,
   parameter int                   SettleCycles = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                abort_i,
   output logic [SelW-1:0]     sel_o,
   input  logic                result_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                pass_o,
   output logic [SelW:0]       err_cnt_o,
   output logic [2**SelW-1:0]  fail_mask_o
);

   localparam int unsigned           NumCodes      = num_codes(SelW);
   localparam logic [SelW-1:0]       LastSel       = SelW'(NumCodes - 1);
   localparam logic [SelW-1:0]       SelOne        = SelW'(1);
   localparam logic [SelW:0]         ErrOne        = (SelW + 1)'(1);
   localparam int                    SettleLoadInt = (SettleCycles > 0) ? SettleCycles - 1 : 0;
   localparam logic [SETTLE_W-1:0]   SettleLoad    = SETTLE_W'(SettleLoadInt);
   localparam bit                    NoSettle      = (SettleCycles == 0);

   sweep_state_e          state_reg, state_next;
   logic [SelW-1:0]       sel_reg;
   logic [SelW:0]         err_cnt_reg;
   logic [NumCodes-1:0]   fail_mask_reg;
   logic                  pass_reg;
   logic [NumCodes-1:0]   code_hit;
   logic                  settle_zero, cnt_load, cnt_dec;
   logic                  accept_start, abort_act, is_last, sample_hit;

   assign accept_start = (state_reg == IDLE) && start_i;
   assign abort_act    = (state_reg != IDLE) && abort_i;
   assign is_last      = (sel_reg == LastSel);
   assign sample_hit   = (state_reg == SAMPLE) && (result_i != ExpMask[sel_reg]);

   truth_sweep_settle_cnt #(.W(SETTLE_W)) u_settle_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (cnt_load),
      .load_val_i (SettleLoad),
      .dec_i      (cnt_dec),
      .zero_o     (settle_zero)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_i) state_next = NoSettle ? SAMPLE : SETTLE;
         SETTLE:  if (settle_zero) state_next = SAMPLE;
         SAMPLE: begin
            if (is_last)        state_next = DONE;
            else if (!NoSettle) state_next = SETTLE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // Abort overrides every other transition of an active sweep.
      if (abort_act) state_next = IDLE;
   end

   always_comb begin
      busy_o   = (state_reg != IDLE);
      done_o   = (state_reg == DONE);
      cnt_load = accept_start || ((state_reg == SAMPLE) && !is_last);
      cnt_dec  = (state_reg == SETTLE) && !settle_zero;
   end

   // One-hot set vector: the code currently being sampled, if it mismatched.
   for (genvar gi = 0; gi < NumCodes; gi++) begin : g_code_hit
      assign code_hit[gi] = sample_hit && (sel_reg == SelW'(gi));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sel_reg       <= '0;
         err_cnt_reg   <= '0;
         fail_mask_reg <= '0;
         pass_reg      <= 1'b0;
      end else if (accept_start) begin
         sel_reg       <= '0;
         err_cnt_reg   <= '0;
         fail_mask_reg <= '0;
         pass_reg      <= 1'b0;
      end else if (abort_act) begin
         sel_reg  <= '0;
         pass_reg <= 1'b0;
      end else begin
         if (sample_hit) begin
            err_cnt_reg   <= err_cnt_reg + ErrOne;
            fail_mask_reg <= fail_mask_reg | code_hit;
         end
         if ((state_reg == SAMPLE) && !is_last) sel_reg <= sel_reg + SelOne;
         if (state_reg == DONE) begin
            pass_reg <= (err_cnt_reg == '0);
            sel_reg  <= '0;
         end
      end
   end

   assign sel_o       = sel_reg;
   assign pass_o      = pass_reg;
   assign err_cnt_o   = err_cnt_reg;
   assign fail_mask_o = fail_mask_reg;

endmodule

// File: doc/truth_sweep_ctrl.md
Name: truth_sweep_ctrl

Overview:
- Sequencer for a 3-input/1-output combinational decoder under test.
- On start, drives the select input through every code, 0 to 2**SelW-1. After a settle delay it samples the decoder output and compares it with an expected truth-table mask.
- Reports pass/fail, an error count and a per-code failure mask.
- Sits between a test/config master and the decoder instance; the decoder's select and result are wired to sel_o and result_i.

Parameters:
- SelW, 3, select width; codes swept = 2**SelW.
- ExpMask, 8'b1010_0101, expected result per code; bit k = expected result for sel==k. Codes 0, 2, 5 and 7 expect 1.
- SettleCycles, 1, cycles sel_o is held before sampling; legal 0..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin a sweep; honoured only in IDLE.
- abort_i  in  1  terminate an active sweep.
- sel_o  out  SelW  select driven to the decoder.
- result_i  in  1  decoder result.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse on sweep completion.
- pass_o  out  1  last completed sweep had zero mismatches.
- err_cnt_o  out  SelW+1  mismatch count of the last sweep.
- fail_mask_o  out  2**SelW  bit k set = code k mismatched.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE, sel_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, fail_mask_o=0, settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start_i=1, at the next edge: go to SETTLE, sel_o=0, err_cnt_o=0, fail_mask_o=0, pass_o=0, settle counter loaded with SettleCycles-1.
  - If SettleCycles=0, go directly to SAMPLE instead.
- SETTLE:
  - Counter decrements each cycle; at 0, go to SAMPLE.
  - sel_o is stable throughout.
- SAMPLE, one cycle:
  - Compare result_i against ExpMask[sel_o].
  - On mismatch: err_cnt_o += 1 and fail_mask_o[sel_o] <= 1.
  - If sel_o == 2**SelW-1, go to DONE. Otherwise sel_o += 1 and return to SETTLE, or stay in SAMPLE when SettleCycles=0.
- DONE, one cycle:
  - done_o=1, pass_o <= (err_cnt_o==0), then go to IDLE.
  - sel_o returns to 0 on entry to IDLE.
- busy_o=1 in SETTLE, SAMPLE and DONE; 0 in IDLE.
- Latency: busy_o is high for exactly 2**SelW*(SettleCycles+1)+1 cycles, the last of which carries done_o. Default parameters: 17 cycles.
- Width rules:
  - err_cnt_o saturates naturally; the maximum is 2**SelW, which fits in SelW+1 bits.
  - sel_o increment never wraps inside a sweep, because the terminal code exits to DONE.
- start_i while busy_o=1 is ignored, with no restart.
- abort_i has priority over all other transitions when busy_o=1:
  - Next state IDLE, sel_o=0, done_o not pulsed, pass_o=0.
  - err_cnt_o and fail_mask_o keep their partial values.
- abort_i in IDLE has no effect. abort_i and start_i together in IDLE: start wins.
- Reset mid-sweep: immediate return to reset values; no done_o.
- result_i is sampled only in SAMPLE; its value in other states is don't-care.
- Results (pass_o, err_cnt_o, fail_mask_o) are stable from DONE until the next accepted start.

Decomposition:
- Package truth_sweep_pkg holds:
  - state enum sweep_state_e {IDLE, SETTLE, SAMPLE, DONE}.
  - Default ExpMask constant DEC5_EXP_MASK = 8'b1010_0101.
  - Localparam helper NumCodes = 2**SelW.
- Optional sub-module truth_sweep_settle_cnt: loadable down-counter with zero flag, reusable for settle timing. The FSM, compare and accumulate logic stay in the top module.
- The decoder itself is instantiated outside this block.

Test Plan:
1. Correct decoder model (result = ExpMask[sel]), pulse start_i:
   - sel_o steps 0..7, each held 2 cycles.
   - done_o pulses on cycle 17 after the start edge.
   - pass_o=1, err_cnt_o=0, fail_mask_o=8'h00.
2. Decoder with code 5 stuck-at-0:
   - pass_o=0, err_cnt_o=1, fail_mask_o=8'h20.
3. Decoder output forced constant 1:
   - Mismatches at codes 1, 3, 4 and 6.
   - err_cnt_o=4, fail_mask_o=8'h5A, pass_o=0.
4. SettleCycles=0, correct model:
   - sel_o increments every cycle; busy_o high for 9 cycles; done_o on the 9th; pass_o=1.
5. Abort at sel_o=3:
   - Next cycle IDLE, busy_o=0, sel_o=0, no done_o, pass_o=0.
   - A following start runs a full clean sweep to pass_o=1.
6. Edge cases:
   - start_i held high throughout a sweep runs only one sweep, then restarts from IDLE.
   - rst_ni asserted at sel_o=6 clears all outputs asynchronously within the same cycle.
